alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Registered execute stage that consumes the 4-bit ALU control code produced by alu control
//  decode, together with two operands, and produces result, zero, overflow and branch_taken.
//  Sits between decode/operand-fetch and writeback/PC-select.
//  Uses valid/ready handshakes on both sides with a 2-entry skid buffer:
//  full throughput, registered in_ready, in-order delivery.
// PARAMETERS
//  W        32   operand/result width (>=2)
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  in_valid       in   1    upstream presents op
//  in_ready       out  1    stage can accept (registered)
//  in_ctl         in   4    ALU control code
//  in_a           in   W    operand A (rs)
//  in_b           in   W    operand B (rt or sign-extended imm)
//  out_valid      out  1    result presented
//  out_ready      in   1    downstream accepts
//  out_result     out  W    computed value
//  out_zero       out  1    out_result == 0
//  out_ovf        out  1    signed overflow, add/sub only, else 0
//  out_taken      out  1    branch condition true (branch codes only, else 0)
//  out_illegal    out  1    in_ctl not in code table
// BEHAVIOUR
//  Codes (A,B signed two's complement):
//   0000 add  A+B                 0001 slt  (A<B)?1:0
//   0010 sub  A-B                 0100 or   A|B
//   1000 and  A&B                 1001 nor  ~(A|B)
//   1010 bne  res=A-B, taken=(A!=B)
//   1011 bgez res=A-B, taken=(A>=0)
//   1100 bgtz res=A-B, taken=(A>0)
//   1101 blez res=A-B, taken=(A<=0)
//   1110 bltz res=A-B, taken=(A<0)
//   Other codes: res=0, zero=1, taken=0, ovf=0, illegal=1.
//  - Width: sums wrap modulo 2^W.
//  - ovf: add when signs of A and B match and differ from the sum; sub when signs of A and B differ
//    and the result sign differs from A.
//  - slt uses the true signed compare, not the sign of the wrapped difference.
//  Handshake:
//   - Transfer occurs on a cycle where valid&&ready is high at the rising edge.
//   - out_* must be held stable while out_valid && !out_ready.
//  Storage: main register (drives out_*) and skid register; results are computed at input accept.
//   - Accept, main empty or draining this cycle: write main. out_valid=1 next cycle (latency 1).
//   - Accept, main held: write skid.
//   - Skid full: in_ready=0 next cycle. in_ready = !skid_valid.
//   - Main drains: skid moves to main the same edge; skid_valid clears.
//   - Simultaneous accept + drain with skid empty: new op goes to main.
//   - Never accept when skid full. Ops never reorder or drop.
//  Reset (async, any time, including mid-transfer):
//   - Immediately clears main_valid and skid_valid; all out_* = 0; in_ready = 1 at rst_n rise.
//   - In-flight ops are discarded.
// STRUCTURE
//  - Shared header alu_codes.vh: localparams for the 11 control codes (ALU_ADD .. ALU_BLTZ),
//    reused by the ALU control decoder.
//  - Sub-module alu_core: purely combinational ctl/a/b -> result/zero/ovf/taken/illegal.
//  - This block contains only the skid-buffer control and registers.
// TESTING
//  1 add 7+(-3), out_ready=1 -> next cycle out_valid=1, result=4, zero=0, ovf=0.
//  2 add 0x7FFFFFFF+1 -> result=0x80000000, ovf=1.
//    slt A=-1, B=1 -> result=1.
//    slt A=0x80000000, B=0x7FFFFFFF -> result=1.
//  3 Branch codes with A=0 -> bgez=1, bgtz=0, blez=1, bltz=0.
//    bne A=5, B=5 -> taken=0, zero=1.
//  4 Back-to-back stream of 3 ops, out_ready low 2 cycles:
//    - in_ready falls after 2nd op; 3rd op held.
//    - On release, results emerge in order with no bubbles.
//  5 ctl=0011 -> illegal=1, result=0, zero=1, taken=0.
//  6 rst_n low mid-stall with both entries full -> out_valid=0 immediately;
//    after release in_ready=1, no stale result appears.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU control codes and result flag bundle for the execute stage and the
// ALU control decoder.
package alu_exec_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BGEZ = 4'b1011;
    localparam logic [3:0] ALU_BGTZ = 4'b1100;
    localparam logic [3:0] ALU_BLEZ = 4'b1101;
    localparam logic [3:0] ALU_BLTZ = 4'b1110;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic taken;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Purely combinational ALU: control code and signed operands in, result and
// zero/overflow/branch/illegal flags out.
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]          ctl_i,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic [W-1:0]        result_o,
    output alu_flags_t          flags_o
);

    logic signed [W-1:0] sum;
    logic signed [W-1:0] diff;
    logic                a_neg;
    logic                a_is_zero;

    assign sum       = a_i + b_i;
    assign diff      = a_i - b_i;
    assign a_neg     = a_i[W-1];
    assign a_is_zero = (a_i == '0);

    always_comb begin
        result_o        = '0;
        flags_o         = '0;
        unique case (ctl_i)
            ALU_ADD: begin
                result_o    = sum;
                flags_o.ovf = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            // Signed compare of the operands themselves; the wrapped difference would lie on overflow.
            ALU_SLT:  result_o = {{(W-1){1'b0}}, (a_i < b_i)};
            ALU_SUB: begin
                result_o    = diff;
                flags_o.ovf = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_BNE: begin
                result_o      = diff;
                flags_o.taken = (a_i != b_i);
            end
            ALU_BGEZ: begin
                result_o      = diff;
                flags_o.taken = !a_neg;
            end
            ALU_BGTZ: begin
                result_o      = diff;
                flags_o.taken = !a_neg && !a_is_zero;
            end
            ALU_BLEZ: begin
                result_o      = diff;
                flags_o.taken = a_neg || a_is_zero;
            end
            ALU_BLTZ: begin
                result_o      = diff;
                flags_o.taken = a_neg;
            end
            default:  flags_o.illegal = 1'b1;
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: results are computed at input accept and held in
// a main/skid register pair so upstream sees a registered ready at full throughput.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_ctl,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_taken,
    output logic         out_illegal
);

    logic [W-1:0] new_res;
    alu_flags_t   new_flg;

    logic [W-1:0] main_res_q, main_res_d, skid_res_q, skid_res_d;
    alu_flags_t   main_flg_q, main_flg_d, skid_flg_q, skid_flg_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         in_ready_q, in_ready_d;
    logic         accept, main_free;

    alu_core #(.W(W)) u_core (
        .ctl_i    (in_ctl),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (new_res),
        .flags_o  (new_flg)
    );

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_vld_q || out_ready;

    always_comb begin
        main_res_d = main_res_q;
        main_flg_d = main_flg_q;
        main_vld_d = main_vld_q;
        skid_res_d = skid_res_q;
        skid_flg_d = skid_flg_q;
        skid_vld_d = skid_vld_q;
        // Skid full implies no accept this cycle, so its refill of main never races a new op.
        if (main_free) begin
            if (skid_vld_q) begin
                main_res_d = skid_res_q;
                main_flg_d = skid_flg_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_res_d = new_res;
                main_flg_d = new_flg;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_res_d = new_res;
            skid_flg_d = new_flg;
            skid_vld_d = 1'b1;
        end
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_res_q <= '0;
            main_flg_q <= '0;
            main_vld_q <= 1'b0;
            skid_res_q <= '0;
            skid_flg_q <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_res_q <= main_res_d;
            main_flg_q <= main_flg_d;
            main_vld_q <= main_vld_d;
            skid_res_q <= skid_res_d;
            skid_flg_q <= skid_flg_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_vld_q;
    assign out_result  = main_res_q;
    assign out_zero    = main_flg_q.zero;
    assign out_ovf     = main_flg_q.ovf;
    assign out_taken   = main_flg_q.taken;
    assign out_illegal = main_flg_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic/branch/illegal vectors, skid-buffer
// back-pressure ordering, and asynchronous reset while both entries are full.
module tb_alu_exec_stage;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_ctl;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_ovf;
    logic         out_taken;
    logic         out_illegal;

    int n_vec;
    int n_err;

    alu_exec_stage #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctl      (in_ctl),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_taken   (out_taken),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op with out_ready high; its result is on out_* one cycle later.
    task automatic apply(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        in_ctl    = ctl;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+5:0] obs, exp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctl    = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        obs = {in_ready, out_valid, out_zero, out_ovf, out_taken, out_illegal, out_result};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_state got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Each row: ctl, a, b, expected {valid,zero,ovf,taken,illegal,result}
    task automatic run_table(input string name, input int n,
                             input logic [3:0] ctls [8], input logic [W-1:0] as [8],
                             input logic [W-1:0] bs [8], input logic [W+4:0] exps [8]);
        logic [W+4:0] obs;
        for (int i = 0; i < n; i++) begin
            apply(ctls[i], as[i], bs[i]);
            obs = {out_valid, out_zero, out_ovf, out_taken, out_illegal, out_result};
            n_vec++;
            if (obs !== exps[i]) begin
                n_err++;
                $display("FAIL %s[%0d] got=%h want=%h", name, i, obs, exps[i]);
            end
        end
        tick();
    endtask

    task automatic test_arith();
        logic [3:0]   c [8];
        logic [W-1:0] a [8];
        logic [W-1:0] b [8];
        logic [W+4:0] e [8];
        c[0] = 4'b0000; a[0] = 32'd7;         b[0] = 32'hFFFF_FFFD; e[0] = {5'b10000, 32'd4};
        c[1] = 4'b0000; a[1] = 32'h7FFF_FFFF; b[1] = 32'd1;         e[1] = {5'b10100, 32'h8000_0000};
        c[2] = 4'b0001; a[2] = 32'hFFFF_FFFF; b[2] = 32'd1;         e[2] = {5'b10000, 32'd1};
        c[3] = 4'b0001; a[3] = 32'h8000_0000; b[3] = 32'h7FFF_FFFF; e[3] = {5'b10000, 32'd1};
        c[4] = 4'b0010; a[4] = 32'h8000_0000; b[4] = 32'd1;         e[4] = {5'b10100, 32'h7FFF_FFFF};
        c[5] = 4'b0000; a[5] = 32'hFFFF_FFFF; b[5] = 32'd1;         e[5] = {5'b11000, 32'd0};
        c[6] = 4'b0001; a[6] = 32'd5;         b[6] = 32'hFFFF_FFFE; e[6] = {5'b11000, 32'd0};
        c[7] = 4'b0010; a[7] = 32'd10;        b[7] = 32'd3;         e[7] = {5'b10000, 32'd7};
        run_table("arith", 8, c, a, b, e);
    endtask

    task automatic test_logic();
        logic [3:0]   c [8];
        logic [W-1:0] a [8];
        logic [W-1:0] b [8];
        logic [W+4:0] e [8];
        for (int i = 0; i < 8; i++) begin
            c[i] = '0; a[i] = '0; b[i] = '0; e[i] = '0;
        end
        c[0] = 4'b0100; a[0] = 32'h0000_00F0; b[0] = 32'h0000_000F; e[0] = {5'b10000, 32'h0000_00FF};
        c[1] = 4'b1000; a[1] = 32'h0000_FF00; b[1] = 32'h0000_0FF0; e[1] = {5'b10000, 32'h0000_0F00};
        c[2] = 4'b1001; a[2] = 32'd0;         b[2] = 32'd0;         e[2] = {5'b10000, 32'hFFFF_FFFF};
        c[3] = 4'b1001; a[3] = 32'hFFFF_0000; b[3] = 32'h0000_FFFF; e[3] = {5'b11000, 32'd0};
        run_table("logic", 4, c, a, b, e);
    endtask

    task automatic test_branch();
        logic [3:0]   c [8];
        logic [W-1:0] a [8];
        logic [W-1:0] b [8];
        logic [W+4:0] e [8];
        c[0] = 4'b1011; a[0] = 32'd0;         b[0] = 32'd0; e[0] = {5'b11010, 32'd0};
        c[1] = 4'b1100; a[1] = 32'd0;         b[1] = 32'd0; e[1] = {5'b11000, 32'd0};
        c[2] = 4'b1101; a[2] = 32'd0;         b[2] = 32'd0; e[2] = {5'b11010, 32'd0};
        c[3] = 4'b1110; a[3] = 32'd0;         b[3] = 32'd0; e[3] = {5'b11000, 32'd0};
        c[4] = 4'b1010; a[4] = 32'd5;         b[4] = 32'd5; e[4] = {5'b11000, 32'd0};
        c[5] = 4'b1010; a[5] = 32'd5;         b[5] = 32'd3; e[5] = {5'b10010, 32'd2};
        c[6] = 4'b1110; a[6] = 32'hFFFF_FFFF; b[6] = 32'd1; e[6] = {5'b10010, 32'hFFFF_FFFE};
        c[7] = 4'b1100; a[7] = 32'd1;         b[7] = 32'd0; e[7] = {5'b10010, 32'd1};
        run_table("branch", 8, c, a, b, e);
    endtask

    task automatic test_illegal();
        logic [3:0]   c [8];
        logic [W-1:0] a [8];
        logic [W-1:0] b [8];
        logic [W+4:0] e [8];
        for (int i = 0; i < 8; i++) begin
            c[i] = '0; a[i] = '0; b[i] = '0; e[i] = '0;
        end
        c[0] = 4'b0011; a[0] = 32'd5;         b[0] = 32'd3;         e[0] = {5'b11001, 32'd0};
        c[1] = 4'b1111; a[1] = 32'hFFFF_FFFF; b[1] = 32'hFFFF_FFFF; e[1] = {5'b11001, 32'd0};
        c[2] = 4'b0111; a[2] = 32'h7FFF_FFFF; b[2] = 32'd1;         e[2] = {5'b11001, 32'd0};
        run_table("illegal", 3, c, a, b, e);
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] obs, exp;
        out_ready = 1'b0;
        in_ctl    = 4'b0000;
        in_valid  = 1'b1;
        in_a = 32'd1; in_b = 32'd1;
        tick();
        obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b1, 32'd2};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_op1_main got=%h want=%h", obs, exp); end
        in_a = 32'd2; in_b = 32'd2;
        tick();
        obs = {in_ready, out_valid, out_result}; exp = {1'b0, 1'b1, 32'd2};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_skid_full got=%h want=%h", obs, exp); end
        in_a = 32'd3; in_b = 32'd3;
        tick();
        obs = {in_ready, out_valid, out_result}; exp = {1'b0, 1'b1, 32'd2};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_stall_hold got=%h want=%h", obs, exp); end
        out_ready = 1'b1;
        tick();
        obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b1, 32'd4};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_release_op2 got=%h want=%h", obs, exp); end
        tick();
        in_valid = 1'b0;
        obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b1, 32'd6};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL b2b_op3 got=%h want=%h", obs, exp); end
        tick();
        obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b0, 32'd6};
        n_vec++;
        if (obs[W+1:W] !== exp[W+1:W]) begin n_err++; $display("FAIL b2b_drained got=%h want=%h", obs, exp); end
    endtask

    task automatic test_reset_midstall();
        logic [W+1:0] obs, exp;
        out_ready = 1'b0;
        in_ctl    = 4'b0000;
        in_valid  = 1'b1;
        in_a = 32'd10; in_b = 32'd1;
        tick();
        in_a = 32'd20; in_b = 32'd1;
        tick();
        in_valid = 1'b0;
        obs = {in_ready, out_valid, out_result}; exp = {1'b0, 1'b1, 32'd11};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rst_pre_full got=%h want=%h", obs, exp); end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b0, {W{1'b0}}};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL rst_async_clear got=%h want=%h", obs, exp); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {in_ready, out_valid, out_result}; exp = {1'b1, 1'b0, {W{1'b0}}};
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL rst_no_stale[%0d] got=%h want=%h", i, obs, exp); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_logic();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_midstall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
